// File: rtl/in_cell_pkg.sv
// Shared definitions for the input cell bank: mode selection, parameter limits,
// and the filter counter width helper.
// Imported by in_cell_bank and in_cell_chan.
package in_cell_pkg;

  typedef enum logic [0:0] {
    MODE_IN_REG  = 1'b0,
    MODE_IN_BUFF = 1'b1
  } mode_e;

  localparam string MODE_STR_REG  = "IN_REG";
  localparam string MODE_STR_BUFF = "IN_BUFF";

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  localparam int SYNC_MIN  = 1;
  localparam int SYNC_MAX  = 4;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 15;

  // Counter only ever holds 0..depth-1, but is sized for 0..depth so it cannot wrap.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/in_cell_chan.sv
// One input channel: pad synchroniser, stability filter and output flop.
// Latency SYNC_STAGES + effective filter depth edges; no backpressure (IQE freezes filter/output only).
// Filter counters exist only when IN_CELL_BANK_FILTER_EN is defined; otherwise output follows sync every enabled cycle.
module in_cell_chan
  import in_cell_pkg::*;
#(
  parameter int   SYNC_STAGES  = 2,
  parameter int   FILTER_DEPTH = 3,
  parameter logic RESET_BIT    = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic pad_i,
  output logic z_o,
  output logic chg_o
);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("in_cell_chan: SYNC_STAGES out of range");
  end
  if (FILTER_DEPTH < DEPTH_MIN || FILTER_DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("in_cell_chan: FILTER_DEPTH out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES:0]   shift_w;
  logic                   sync_out;
  logic                   z_q, z_d;
  logic                   chg_q, chg_d;

  assign shift_w  = {sync_q, pad_i};
  assign sync_d   = shift_w[SYNC_STAGES-1:0];
  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef IN_CELL_BANK_FILTER_EN
  localparam int                CW       = cnt_width(FILTER_DEPTH);
  localparam logic [CW-1:0]     CNT_LAST = CW'(FILTER_DEPTH - 1);
  logic [CW-1:0]                cnt_q, cnt_d;
`endif

  // Next-state: count stable disagreeing cycles, commit the sync value once the run is long enough.
  always_comb begin
    z_d   = z_q;
    chg_d = 1'b0;
`ifdef IN_CELL_BANK_FILTER_EN
    cnt_d = cnt_q;
    if (en_i) begin
      if (sync_out != z_q) begin
        if (cnt_q == CNT_LAST) begin
          z_d   = sync_out;
          cnt_d = '0;
          chg_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
`else
    if (en_i && (sync_out != z_q)) begin
      z_d   = sync_out;
      chg_d = 1'b1;
    end
`endif
  end

  // Synchroniser shifts every cycle; output and change pulse obey the capture enable via z_d/chg_d.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_BIT}};
      z_q    <= RESET_BIT;
      chg_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      z_q    <= z_d;
      chg_q  <= chg_d;
    end
  end

`ifdef IN_CELL_BANK_FILTER_EN
  // Filter run-length counter; reset discards any pending transition.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign z_o   = z_q;
  assign chg_o = chg_q;

endmodule

// File: rtl/in_cell_bank.sv
// Bank of WIDTH independent input cells (registered+filtered or plain pass-through).
// IN_REG latency SYNC_STAGES + FILTER_DEPTH edges (depth 1 without IN_CELL_BANK_FILTER_EN); IN_BUFF is combinational.
// No backpressure; IQE low freezes output registers and filter counters. Macro: IN_CELL_BANK_FILTER_EN.
module in_cell_bank
  import in_cell_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter string            MODE         = "IN_REG",
  parameter int               SYNC_STAGES  = 2,
  parameter int               FILTER_DEPTH = 3,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic             IQC,
  input  logic             QRT,
  input  logic             IQE,
  input  logic [WIDTH-1:0] in_pad,
  output logic [WIDTH-1:0] IQZ,
  output logic [WIDTH-1:0] IQZ_CHG
);

  localparam mode_e MODE_SEL = (MODE == MODE_STR_BUFF) ? MODE_IN_BUFF : MODE_IN_REG;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("in_cell_bank: WIDTH out of range");
  end
  if (MODE != MODE_STR_REG && MODE != MODE_STR_BUFF) begin : g_bad_mode
    $error("in_cell_bank: MODE must be IN_REG or IN_BUFF");
  end
  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("in_cell_bank: SYNC_STAGES out of range");
  end
  if (FILTER_DEPTH < DEPTH_MIN || FILTER_DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("in_cell_bank: FILTER_DEPTH out of range");
  end

  if (MODE_SEL == MODE_IN_BUFF) begin : g_buff
    // Pure pass-through: clock, reset and enable have no effect in this mode.
    logic unused_ctl;
    assign unused_ctl = ^{IQC, QRT, IQE};
    assign IQZ        = in_pad;
    assign IQZ_CHG    = '0;
  end else begin : g_reg
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      in_cell_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_DEPTH(FILTER_DEPTH),
        .RESET_BIT   (RESET_VAL[i])
      ) u_chan (
        .clk_i(IQC),
        .rst_i(QRT),
        .en_i (IQE),
        .pad_i(in_pad[i]),
        .z_o  (IQZ[i]),
        .chg_o(IQZ_CHG[i])
      );
    end
  end

endmodule
